instr_encoder: RTL and testbench

- Inverse of the datapath immediate extender: packs register, opcode and immediate fields into 32-bit instruction words.
- Supported layouts:
  - Format (a): RSRC1[31:27] RSRC2[26:22] RDST[21:17] OPCODE[16:0].
  - Format (b): RSRC1[31:27] RDST[26:22] IMM[21:6] OPCODE[5:0].
  - Format (c): IMM[31:6] OPCODE[5:0].
- Range-checks each immediate so that extending it back under the same extend code reproduces the original 32-bit value.
- Sits between the loader/test host and instruction memory. Emits each word with a sequential address over a valid/ready handshake.

---
 rtl/instr_encoder_pkg.sv | 43 ++++
 rtl/instr_encoder_if.sv | 40 ++++
 rtl/instr_encoder_field_check.sv | 45 ++++
 rtl/instr_encoder.sv | 119 +++++++++++
 tb/tb_instr_encoder.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder.
// Holds the layout selectors, the extend codes (the same encoding the
// datapath immediate extender consumes), the rejection codes and the
// bit positions of every field in the three instruction layouts.
package instr_encoder_pkg;

    typedef enum logic [1:0] {
        FMT_A    = 2'd0,
        FMT_B    = 2'd1,
        FMT_C    = 2'd2,
        FMT_RSVD = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        EXT_S16 = 2'd0,
        EXT_Z16 = 2'd1,
        EXT_S26 = 2'd2,
        EXT_Z26 = 2'd3
    } ext_e;

    // Listed lowest priority first; the checker reports the highest one hit.
    typedef enum logic [1:0] {
        ERR_IMM = 2'd0,
        ERR_OPC = 2'd1,
        ERR_EXT = 2'd2,
        ERR_FMT = 2'd3
    } err_e;

    localparam int REG_W     = 5;
    localparam int OPC_A_W   = 17;
    localparam int OPC_BC_W  = 6;
    localparam int IMM_B_W   = 16;
    localparam int IMM_C_W   = 26;

    localparam int A_RS1_LSB = 27;
    localparam int A_RS2_LSB = 22;
    localparam int A_RD_LSB  = 17;
    localparam int B_RS1_LSB = 27;
    localparam int B_RD_LSB  = 22;
    localparam int B_IMM_LSB = 6;
    localparam int C_IMM_LSB = 6;

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle between the loader (master) and the encoder
// (slave): encode request fields with in_valid/in_ready, address-counter
// load, encoded word with out_valid/out_ready, and rejection reporting.
interface instr_encoder_if #(
    parameter int ADDR_W   = 8,
    parameter int ERRCNT_W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          fmt;
    logic [1:0]          extend;
    logic [16:0]         opcode;
    logic [4:0]          rsrc1;
    logic [4:0]          rsrc2;
    logic [4:0]          rdst;
    logic [31:0]         imm;
    logic                addr_load;
    logic [ADDR_W-1:0]   addr_in;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_word;
    logic [ADDR_W-1:0]   out_addr;
    logic                err_pulse;
    logic [1:0]          err_code;
    logic [ERRCNT_W-1:0] err_count;

    modport slave (
        input  in_valid, fmt, extend, opcode, rsrc1, rsrc2, rdst, imm,
               addr_load, addr_in, out_ready,
        output in_ready, out_valid, out_word, out_addr,
               err_pulse, err_code, err_count
    );

    modport master (
        output in_valid, fmt, extend, opcode, rsrc1, rsrc2, rdst, imm,
               addr_load, addr_in, out_ready,
        input  in_ready, out_valid, out_word, out_addr,
               err_pulse, err_code, err_count
    );
endinterface

// File: rtl/instr_encoder_field_check.sv
// Combinational validity check of one encode request.
// Inputs : fmt, extend, opcode, imm.
// Outputs: ok (request may be encoded), err_code (highest-priority reason
//          when ok is low).
module instr_field_check
    import instr_encoder_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [1:0]  extend,
    input  logic [16:0] opcode,
    input  logic [31:0] imm,
    output logic        ok,
    output logic [1:0]  err_code
);

    logic imm_ok;

    always_comb begin
        ok       = 1'b0;
        err_code = ERR_IMM;
        imm_ok   = 1'b0;

        // The immediate survives a round trip through the extender only if
        // every bit above the kept field equals the extension bit.
        case (extend)
            EXT_S16: imm_ok = (&imm[31:15]) || !(|imm[31:15]);
            EXT_Z16: imm_ok = !(|imm[31:16]);
            EXT_S26: imm_ok = (&imm[31:25]) || !(|imm[31:25]);
            default: imm_ok = !(|imm[31:26]);
        endcase

        if (fmt == FMT_RSVD) begin
            err_code = ERR_FMT;
        end else if ((fmt == FMT_B && extend[1]) || (fmt == FMT_C && !extend[1])) begin
            err_code = ERR_EXT;
        end else if (fmt != FMT_A && (|opcode[16:OPC_BC_W])) begin
            err_code = ERR_OPC;
        end else if (fmt != FMT_A && !imm_ok) begin
            err_code = ERR_IMM;
        end else begin
            ok = 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs register, opcode and immediate fields into 32-bit instruction words
// and hands them to instruction memory with a sequential address.
// Ports: clk, rst_n (async, active low), bus (instr_encoder_if.slave) with
//        the request, address-load, output-word and rejection signals.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int ERRCNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_encoder_if.slave bus
);

    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_word_q,  out_word_d;
    logic [ADDR_W-1:0]   out_addr_q,  out_addr_d;
    logic [ADDR_W-1:0]   cnt_q,       cnt_d;
    logic                err_pulse_q, err_pulse_d;
    logic [1:0]          err_code_q,  err_code_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;

    logic              req_ok;
    logic [1:0]        req_code;
    logic              accept;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       packed_word;

    instr_field_check u_check (
        .fmt      (bus.fmt),
        .extend   (bus.extend),
        .opcode   (bus.opcode),
        .imm      (bus.imm),
        .ok       (req_ok),
        .err_code (req_code)
    );

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // A same-cycle address load takes effect for the word being accepted.
    assign base_addr = bus.addr_load ? bus.addr_in : cnt_q;

    always_comb begin
        packed_word = '0;
        case (bus.fmt)
            FMT_A: begin
                packed_word[A_RS1_LSB +: REG_W]   = bus.rsrc1;
                packed_word[A_RS2_LSB +: REG_W]   = bus.rsrc2;
                packed_word[A_RD_LSB  +: REG_W]   = bus.rdst;
                packed_word[0 +: OPC_A_W]         = bus.opcode;
            end
            FMT_B: begin
                packed_word[B_RS1_LSB +: REG_W]   = bus.rsrc1;
                packed_word[B_RD_LSB  +: REG_W]   = bus.rdst;
                packed_word[B_IMM_LSB +: IMM_B_W] = bus.imm[IMM_B_W-1:0];
                packed_word[0 +: OPC_BC_W]        = bus.opcode[OPC_BC_W-1:0];
            end
            default: begin
                packed_word[C_IMM_LSB +: IMM_C_W] = bus.imm[IMM_C_W-1:0];
                packed_word[0 +: OPC_BC_W]        = bus.opcode[OPC_BC_W-1:0];
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q && !bus.out_ready;
        out_word_d  = out_word_q;
        out_addr_d  = out_addr_q;
        cnt_d       = base_addr;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        err_count_d = err_count_q;

        if (accept) begin
            if (req_ok) begin
                out_valid_d = 1'b1;
                out_word_d  = packed_word;
                out_addr_d  = base_addr;
                cnt_d       = base_addr + ADDR_W'(1);
            end else begin
                err_pulse_d = 1'b1;
                err_code_d  = req_code;
                if (err_count_q != '1) begin
                    err_count_d = err_count_q + ERRCNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_addr_q  <= '0;
            cnt_q       <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= '0;
            err_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_addr_q  <= out_addr_d;
            cnt_q       <= cnt_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_code  = err_code_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: a table of directed encode requests with
// hand-computed words/codes, followed by hand-written sequences for
// backpressure, address load and wrap, error-count saturation and reset
// during a pending word.
module tb_instr_encoder;

    logic clk;
    logic rst_n;

    instr_encoder_if #(.ADDR_W(8), .ERRCNT_W(8)) bus ();

    instr_encoder #(.ADDR_W(8), .ERRCNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [1:0]  ext;
        logic [16:0] opc;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [31:0] imm;
        bit          exp_err;
        logic [1:0]  exp_code;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [15];
    int   tests_run;
    int   tests_failed;
    logic [7:0] model_addr;
    logic [7:0] model_errs;

    function automatic vec_t mk(input logic [1:0] fmt, input logic [1:0] ext,
                                input logic [16:0] opc, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] rd,
                                input logic [31:0] imm, input bit exp_err,
                                input logic [1:0] exp_code, input logic [31:0] exp_word);
        vec_t v;
        v.fmt = fmt; v.ext = ext; v.opc = opc; v.r1 = r1; v.r2 = r2; v.rd = rd;
        v.imm = imm; v.exp_err = exp_err; v.exp_code = exp_code; v.exp_word = exp_word;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        bus.fmt    = v.fmt;
        bus.extend = v.ext;
        bus.opcode = v.opc;
        bus.rsrc1  = v.r1;
        bus.rsrc2  = v.r2;
        bus.rdst   = v.rd;
        bus.imm    = v.imm;
    endtask

    task automatic model_reject();
        if (model_errs != 8'hFF) model_errs++;
    endtask

    // One request presented for exactly one clock edge, sampled 1 ns later.
    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        drive_req(v);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic check_output(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        if (v.exp_err) begin
            model_reject();
            check({tag, " err_pulse"}, 32'(bus.err_pulse), 32'd1);
            check({tag, " err_code"},  32'(bus.err_code), 32'(v.exp_code));
            check({tag, " err_count"}, 32'(bus.err_count), 32'(model_errs));
            check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
        end else begin
            check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, " out_word"},  bus.out_word, v.exp_word);
            check({tag, " out_addr"},  32'(bus.out_addr), 32'(model_addr));
            check({tag, " err_pulse"}, 32'(bus.err_pulse), 32'd0);
            model_addr++;
        end
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.addr_load = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " idle err_pulse"}, 32'(bus.err_pulse), 32'd0);
        check({tag, " idle out_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        vec_t v;
        tests_run    = 0;
        tests_failed = 0;
        model_addr   = 8'h00;
        model_errs   = 8'h00;

        //            fmt   ext   opcode     r1     r2     rd     imm           err  code  word
        vecs[0]  = mk(2'd0, 2'd0, 17'h1ABCD, 5'd1,  5'd2,  5'd3,  32'h00000000, 0, 2'd0, 32'h0887ABCD);
        vecs[1]  = mk(2'd1, 2'd0, 17'h00005, 5'd3,  5'd0,  5'd7,  32'hFFFFFFFE, 0, 2'd0, 32'h19FFFF85);
        vecs[2]  = mk(2'd2, 2'd3, 17'h0003F, 5'd0,  5'd0,  5'd0,  32'h03FFFFFF, 0, 2'd0, 32'hFFFFFFFF);
        vecs[3]  = mk(2'd1, 2'd1, 17'h00000, 5'd0,  5'd0,  5'd0,  32'h00010000, 1, 2'd0, 32'h0);
        vecs[4]  = mk(2'd3, 2'd0, 17'h00040, 5'd0,  5'd0,  5'd0,  32'h00000000, 1, 2'd3, 32'h0);
        vecs[5]  = mk(2'd1, 2'd2, 17'h00000, 5'd0,  5'd0,  5'd0,  32'h00000000, 1, 2'd2, 32'h0);
        vecs[6]  = mk(2'd2, 2'd0, 17'h00000, 5'd0,  5'd0,  5'd0,  32'h00000000, 1, 2'd2, 32'h0);
        vecs[7]  = mk(2'd1, 2'd0, 17'h00040, 5'd0,  5'd0,  5'd0,  32'h00000000, 1, 2'd1, 32'h0);
        vecs[8]  = mk(2'd1, 2'd0, 17'h00001, 5'd0,  5'd0,  5'd0,  32'h00008000, 1, 2'd0, 32'h0);
        vecs[9]  = mk(2'd1, 2'd0, 17'h00001, 5'd0,  5'd0,  5'd0,  32'hFFFF8000, 0, 2'd0, 32'h00200001);
        vecs[10] = mk(2'd2, 2'd2, 17'h00002, 5'd0,  5'd0,  5'd0,  32'hFE000000, 0, 2'd0, 32'h80000002);
        vecs[11] = mk(2'd2, 2'd2, 17'h00000, 5'd0,  5'd0,  5'd0,  32'h02000000, 1, 2'd0, 32'h0);
        vecs[12] = mk(2'd2, 2'd3, 17'h00000, 5'd0,  5'd0,  5'd0,  32'h04000000, 1, 2'd0, 32'h0);
        vecs[13] = mk(2'd1, 2'd1, 17'h0003F, 5'd31, 5'd0,  5'd31, 32'h0000FFFF, 0, 2'd0, 32'hFFFFFFFF);
        vecs[14] = mk(2'd0, 2'd3, 17'h1FFFF, 5'd0,  5'd0,  5'd0,  32'h12345678, 0, 2'd0, 32'h0001FFFF);

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.addr_load = 1'b0;
        bus.addr_in   = 8'h00;
        bus.out_ready = 1'b1;
        v = mk(2'd0, 2'd0, 17'h0, 5'd0, 5'd0, 5'd0, 32'h0, 0, 2'd0, 32'h0);
        drive_req(v);
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_word",  bus.out_word, 32'd0);
        check("reset out_addr",  32'(bus.out_addr), 32'd0);
        check("reset err_pulse", 32'(bus.err_pulse), 32'd0);
        check("reset err_code",  32'(bus.err_code), 32'd0);
        check("reset err_count", 32'(bus.err_count), 32'd0);
        check("reset in_ready",  32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i], i);
            idle_cycle($sformatf("vec%0d", i));
        end

        // Backpressure: first word stalls for three cycles while the next
        // request waits, then the waiting request issues at the next address.
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_req(mk(2'd0, 2'd0, 17'h00011, 5'd0, 5'd0, 5'd0, 32'h0, 0, 2'd0, 32'h0));
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("bp first word", bus.out_word, 32'h00000011);
        @(negedge clk);
        drive_req(mk(2'd0, 2'd0, 17'h00022, 5'd0, 5'd0, 5'd0, 32'h0, 0, 2'd0, 32'h0));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp stall%0d in_ready", c), 32'(bus.in_ready), 32'd0);
            check($sformatf("bp stall%0d out_word", c), bus.out_word, 32'h00000011);
            check($sformatf("bp stall%0d out_addr", c), 32'(bus.out_addr), 32'(model_addr));
            check($sformatf("bp stall%0d out_valid", c), 32'(bus.out_valid), 32'd1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release out_word", bus.out_word, 32'h00000022);
        check("bp release out_addr", 32'(bus.out_addr), 32'(model_addr + 8'd1));
        model_addr = model_addr + 8'd2;
        idle_cycle("bp");

        // Address load with an accepted request, then wrap past 0xFF.
        @(negedge clk);
        bus.addr_load = 1'b1;
        bus.addr_in   = 8'hFF;
        drive_req(mk(2'd0, 2'd0, 17'h00003, 5'd0, 5'd0, 5'd0, 32'h0, 0, 2'd0, 32'h0));
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("load out_addr", 32'(bus.out_addr), 32'h000000FF);
        @(negedge clk);
        bus.addr_load = 1'b0;
        drive_req(mk(2'd0, 2'd0, 17'h00004, 5'd0, 5'd0, 5'd0, 32'h0, 0, 2'd0, 32'h0));
        @(posedge clk);
        #1;
        check("wrap out_addr", 32'(bus.out_addr), 32'h00000000);
        check("wrap out_word", bus.out_word, 32'h00000004);

        // Address load together with a rejection still moves the counter.
        @(negedge clk);
        bus.addr_load = 1'b1;
        bus.addr_in   = 8'h10;
        drive_req(mk(2'd3, 2'd0, 17'h0, 5'd0, 5'd0, 5'd0, 32'h0, 0, 2'd0, 32'h0));
        @(posedge clk);
        #1;
        model_reject();
        check("load+reject err_pulse", 32'(bus.err_pulse), 32'd1);
        @(negedge clk);
        bus.addr_load = 1'b0;
        drive_req(mk(2'd0, 2'd0, 17'h00005, 5'd0, 5'd0, 5'd0, 32'h0, 0, 2'd0, 32'h0));
        @(posedge clk);
        #1;
        check("load+reject next addr", 32'(bus.out_addr), 32'h00000010);
        model_addr = 8'h11;
        idle_cycle("load");

        // 256 back-to-back rejections must pin the counter at all-ones.
        @(negedge clk);
        drive_req(mk(2'd3, 2'd0, 17'h0, 5'd0, 5'd0, 5'd0, 32'h0, 0, 2'd0, 32'h0));
        bus.in_valid = 1'b1;
        repeat (256) @(posedge clk);
        #1;
        check("sat err_count", 32'(bus.err_count), 32'h000000FF);
        check("sat err_code",  32'(bus.err_code), 32'd3);
        idle_cycle("sat");
        check("sat held", 32'(bus.err_count), 32'h000000FF);

        // Reset while a word is pending drops it and clears the counters.
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_req(mk(2'd0, 2'd0, 17'h00077, 5'd0, 5'd0, 5'd0, 32'h0, 0, 2'd0, 32'h0));
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-reset out_valid", 32'(bus.out_valid), 32'd0);
        check("mid-reset err_count", 32'(bus.err_count), 32'd0);
        check("mid-reset out_addr",  32'(bus.out_addr), 32'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        model_addr    = 8'h00;
        model_errs    = 8'h00;
        v = mk(2'd0, 2'd0, 17'h00099, 5'd0, 5'd0, 5'd0, 32'h0, 0, 2'd0, 32'h00000099);
        apply_stimulus(v);
        check_output(v, 99);
        idle_cycle("post-reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
